// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and the
// width helper for the shared GAP/HOLD counter.
package gf180mcu_fd_sc_mcu9t5v0__rstseq_pkg;

    typedef enum logic [2:0] {
        ST_SYNC      = 3'd0,
        ST_RELEASE   = 3'd1,
        ST_RUN       = 3'd2,
        ST_SOFT      = 3'd3,
        ST_WAIT_DROP = 3'd4
    } state_e;

    function automatic int cnt_width(input int gap, input int hold);
        int m;
        m = (gap > hold) ? gap : hold;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq_ctrl_if.sv
// Soft-reset handshake and domain-reset bundle between the sequencer (slave)
// and the logic that requests soft resets and consumes RN_O (master).
interface gf180mcu_fd_sc_mcu9t5v0__rstseq_ctrl_if #(
    parameter int N_DOM = 4
) ();
    import gf180mcu_fd_sc_mcu9t5v0__rstseq_pkg::*;

    // Handshake: SRST_REQ is a level mask held until SRST_ACK pulses for one
    // cycle; it must return to zero before a new request is accepted.
    logic [N_DOM-1:0] SRST_REQ;
    logic [N_DOM-1:0] RN_O;
    logic             READY;
    logic             SRST_BUSY;
    logic             SRST_ACK;
    state_e           dbg_state;

    modport master (
        output SRST_REQ,
        input  RN_O, READY, SRST_BUSY, SRST_ACK, dbg_state
    );

    modport slave (
        input  SRST_REQ,
        output RN_O, READY, SRST_BUSY, SRST_ACK, dbg_state
    );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rst_sync.sv
// Async-assert / sync-deassert reset synchroniser, a chain of
// dffrnq-equivalent flops cleared directly by the pad reset.
module gf180mcu_fd_sc_mcu9t5v0__rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rn_i,
    output logic rn_sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rn_i) begin
        if (!rn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rn_sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq_ctrl.sv
// Reset sequencer: staged release of active-low domain resets after the
// synchronised chip reset, then per-domain soft resets via req/ack.
module gf180mcu_fd_sc_mcu9t5v0__rstseq_ctrl
    import gf180mcu_fd_sc_mcu9t5v0__rstseq_pkg::*;
#(
    parameter int N_DOM       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GAP         = 8,
    parameter int HOLD        = 16
) (
    input  logic CLK,
    input  logic RN,
    gf180mcu_fd_sc_mcu9t5v0__rstseq_ctrl_if.slave bus
);

    localparam int             CW        = cnt_width(GAP, HOLD);
    localparam logic [CW-1:0]  GAP_LAST  = CW'(GAP - 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD - 1);

    logic             rn_sync_n;
    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [N_DOM-1:0] mask_q;
    logic [N_DOM-1:0] rn_o_q;
    logic             ready_q;
    logic             busy_q;
    logic             ack_q;
    logic [N_DOM-1:0] rn_rel_d;

    gf180mcu_fd_sc_mcu9t5v0__rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk_i     (CLK),
        .rn_i      (RN),
        .rn_sync_o (rn_sync_n)
    );

    // Thermometer release: the next domain up is freed each time the gap expires.
    assign rn_rel_d = (rn_o_q << 1) | N_DOM'(1);

    always_ff @(posedge CLK or negedge rn_sync_n) begin
        if (!rn_sync_n) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            mask_q  <= '0;
            rn_o_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                // SYNC is the first edge out of reset and already counts toward the first gap.
                ST_SYNC, ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q  <= '0;
                        rn_o_q <= rn_rel_d;
                        if (&rn_rel_d) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RUN: begin
                    if (|bus.SRST_REQ) begin
                        mask_q  <= bus.SRST_REQ;
                        rn_o_q  <= rn_o_q & ~bus.SRST_REQ;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_SOFT;
                    end
                end
                ST_SOFT: begin
                    if (cnt_q == HOLD_LAST) begin
                        rn_o_q  <= rn_o_q | mask_q;
                        busy_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_DROP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_WAIT_DROP: begin
                    if (bus.SRST_REQ == '0) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_SYNC;
                end
            endcase
        end
    end

    assign bus.RN_O      = rn_o_q;
    assign bus.READY     = ready_q;
    assign bus.SRST_BUSY = busy_q;
    assign bus.SRST_ACK  = ack_q;
    assign bus.dbg_state = state_q;

endmodule
